vr_xmit_gen: RTL and testbench

Parametrised multi-channel valid/ready traffic generator. It is the synthesizable successor to the single-channel testbench transmitter. Each of NUM_CHAN channels drives an independent valid/data stream with a proper hold-until-accepted handshake, selectable inter-transfer gap mode, selectable data pattern and a per-channel transfer counter. It sits on the producer side of valid/ready links in xmit/recv benches and loopback designs.

---
 rtl/vr_xmit_gen.sv | 164 ++++++++++++++++
 tb/tb_vr_xmit_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vr_xmit_gen.sv
// Multi-channel valid/ready traffic generator: each channel runs its own handshake FSM,
// gap timer, data pattern generator and accepted-transfer counter.
module vr_xmit_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CHAN   = 2,
    parameter int GAP_W      = 5,
    parameter int CNT_WIDTH  = 16,
    parameter int SEED       = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CHAN-1:0]             enable,
    input  logic [1:0]                      gap_mode,
    input  logic [GAP_W-1:0]                fixed_gap,
    input  logic                            pattern,
    input  logic [NUM_CHAN-1:0]             ready,
    output logic [NUM_CHAN-1:0]             valid,
    output logic [NUM_CHAN*DATA_WIDTH-1:0]  data,
    output logic [NUM_CHAN*CNT_WIDTH-1:0]   sent_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_VALID, ST_GAP} state_t;

    // Galois right-shift feedback masks of maximal-length polynomials, widths 2..32.
    function automatic logic [31:0] lfsr_mask(input int w);
        case (w)
            2:  lfsr_mask = 32'h0000_0003;
            3:  lfsr_mask = 32'h0000_0006;
            4:  lfsr_mask = 32'h0000_000C;
            5:  lfsr_mask = 32'h0000_0014;
            6:  lfsr_mask = 32'h0000_0030;
            7:  lfsr_mask = 32'h0000_0060;
            8:  lfsr_mask = 32'h0000_00B8;
            9:  lfsr_mask = 32'h0000_0110;
            10: lfsr_mask = 32'h0000_0240;
            11: lfsr_mask = 32'h0000_0500;
            12: lfsr_mask = 32'h0000_0829;
            13: lfsr_mask = 32'h0000_100D;
            14: lfsr_mask = 32'h0000_2015;
            15: lfsr_mask = 32'h0000_6000;
            16: lfsr_mask = 32'h0000_D008;
            17: lfsr_mask = 32'h0001_2000;
            18: lfsr_mask = 32'h0002_0400;
            19: lfsr_mask = 32'h0004_0023;
            20: lfsr_mask = 32'h0009_0000;
            21: lfsr_mask = 32'h0014_0000;
            22: lfsr_mask = 32'h0030_0000;
            23: lfsr_mask = 32'h0042_0000;
            24: lfsr_mask = 32'h00E1_0000;
            25: lfsr_mask = 32'h0120_0000;
            26: lfsr_mask = 32'h0200_0023;
            27: lfsr_mask = 32'h0400_0013;
            28: lfsr_mask = 32'h0900_0000;
            29: lfsr_mask = 32'h1400_0000;
            30: lfsr_mask = 32'h2000_0029;
            31: lfsr_mask = 32'h4800_0000;
            default: lfsr_mask = 32'h8020_0003;
        endcase
    endfunction

    localparam logic [DATA_WIDTH-1:0] DMASK = DATA_WIDTH'(lfsr_mask(DATA_WIDTH));
    localparam logic [15:0]           GMASK = 16'hB400;  // taps 16,14,13,11

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            localparam logic [DATA_WIDTH-1:0] SEED_RAW = DATA_WIDTH'(SEED + gi);
            localparam logic [DATA_WIDTH-1:0] SEED_V   = (SEED_RAW == '0) ? DATA_WIDTH'(1) : SEED_RAW;
            localparam logic [15:0]           GSEED    = 16'(32'hACE1 + gi);

            state_t                state_q, state_d;
            logic [DATA_WIDTH-1:0] data_q, data_d, next_data;
            logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
            logic [GAP_W-1:0]      gap_q, gap_d, gap_val;
            logic [15:0]           glfsr_q, glfsr_d;
            logic                  first_q, first_d;
            logic                  xfer;
            logic                  valid_o;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    data_q  <= '0;
                    cnt_q   <= '0;
                    gap_q   <= '0;
                    glfsr_q <= GSEED;
                    first_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    data_q  <= data_d;
                    cnt_q   <= cnt_d;
                    gap_q   <= gap_d;
                    glfsr_q <= glfsr_d;
                    first_q <= first_d;
                end
            end

            always_comb begin
                xfer = (state_q == ST_VALID) && ready[gi];
                // Random gap uses the low GAP_W bits of the 16-bit gap LFSR (GAP_W <= 16).
                case (gap_mode)
                    2'd1:    gap_val = fixed_gap;
                    2'd2:    gap_val = glfsr_q[GAP_W-1:0];
                    default: gap_val = '0;
                endcase
                // A zero register (only possible after incrementing) restarts the LFSR at its seed.
                if (pattern)
                    next_data = (data_q == '0) ? SEED_V
                              : ((data_q >> 1) ^ (data_q[0] ? DMASK : '0));
                else
                    next_data = data_q + 1'b1;

                state_d = state_q;
                data_d  = data_q;
                cnt_d   = cnt_q;
                gap_d   = gap_q;
                glfsr_d = glfsr_q;
                first_d = first_q;
                case (state_q)
                    ST_IDLE: begin
                        if (enable[gi]) begin
                            state_d = ST_VALID;
                            if (first_q) begin
                                data_d  = pattern ? SEED_V : '0;
                                first_d = 1'b0;
                            end
                        end
                    end
                    ST_VALID: begin
                        if (xfer) begin
                            cnt_d   = cnt_q + 1'b1;
                            data_d  = next_data;
                            glfsr_d = glfsr_q[0] ? ((glfsr_q >> 1) ^ GMASK) : (glfsr_q >> 1);
                            if (!enable[gi]) begin
                                state_d = ST_IDLE;
                            end else if (gap_val != '0) begin
                                state_d = ST_GAP;
                                gap_d   = gap_val;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (!enable[gi])
                            state_d = ST_IDLE;
                        else if (gap_q <= GAP_W'(1))
                            state_d = ST_VALID;
                        else
                            gap_d = gap_q - 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            always_comb begin
                valid_o = (state_q == ST_VALID);
            end

            assign valid[gi]                               = valid_o;
            assign data[gi*DATA_WIDTH +: DATA_WIDTH]       = data_q;
            assign sent_count[gi*CNT_WIDTH +: CNT_WIDTH]   = cnt_q;
        end
    endgenerate

endmodule

// File: tb/tb_vr_xmit_gen.sv
// Directed + randomized bench for vr_xmit_gen, checked against a cycle-level behavioural model.
module tb_vr_xmit_gen;
    localparam int DW = 8;
    localparam int NC = 2;
    localparam int GW = 5;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   enable;
    logic [1:0]      gap_mode;
    logic [GW-1:0]   fixed_gap;
    logic            pattern;
    logic [NC-1:0]   ready;
    logic [NC-1:0]   valid;
    logic [NC*DW-1:0] data;
    logic [NC*CW-1:0] sent_count;

    vr_xmit_gen #(.DATA_WIDTH(DW), .NUM_CHAN(NC), .GAP_W(GW), .CNT_WIDTH(CW), .SEED(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .gap_mode(gap_mode), .fixed_gap(fixed_gap),
        .pattern(pattern), .ready(ready), .valid(valid), .data(data), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a channel is either off, waiting out m_gap idle cycles, or presenting a word.
    bit          m_on[NC];
    int          m_gap[NC];
    bit          m_first[NC];
    logic [7:0]  m_data[NC];
    logic [7:0]  m_cnt[NC];
    logic [15:0] m_glfsr[NC];
    logic [7:0]  xq[$];

    function automatic logic [7:0] seed_of(input int c);
        seed_of = 8'(1 + c);
    endfunction

    // x^8 + x^6 + x^5 + x^4 + 1, right-shifting Galois form
    function automatic logic [7:0] lfsr8(input logic [7:0] x);
        lfsr8 = x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
    endfunction

    function automatic logic [15:0] lfsr16(input logic [15:0] x);
        int taps[4] = '{16, 14, 13, 11};
        logic [15:0] m = '0;
        foreach (taps[k]) m[taps[k]-1] = 1'b1;
        lfsr16 = x[0] ? ((x >> 1) ^ m) : (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_on[c] = 0; m_gap[c] = 0; m_first[c] = 1;
            m_data[c] = '0; m_cnt[c] = '0; m_glfsr[c] = 16'(32'hACE1 + c);
        end
    endtask

    task automatic model_tick();
        int g;
        for (int c = 0; c < NC; c++) begin
            if (m_on[c] && m_gap[c] == 0) begin
                if (ready[c]) begin
                    m_cnt[c]++;
                    if (pattern) m_data[c] = (m_data[c] == 0) ? seed_of(c) : lfsr8(m_data[c]);
                    else         m_data[c] = m_data[c] + 8'd1;
                    g = (gap_mode == 2'd1) ? int'(fixed_gap)
                      : (gap_mode == 2'd2) ? int'(m_glfsr[c] % 32) : 0;
                    m_glfsr[c] = lfsr16(m_glfsr[c]);
                    if (!enable[c]) m_on[c] = 0;
                    else            m_gap[c] = g;
                end
            end else if (m_on[c]) begin
                if (!enable[c]) m_on[c] = 0;
                else            m_gap[c]--;
            end else if (enable[c]) begin
                m_on[c] = 1; m_gap[c] = 0;
                if (m_first[c]) begin
                    m_data[c] = pattern ? seed_of(c) : 8'd0;
                    m_first[c] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("valid%0d", c), 32'(valid[c]), 32'(m_on[c] && m_gap[c] == 0));
            chk($sformatf("data%0d", c), 32'(data[c*DW +: DW]), 32'(m_data[c]));
            chk($sformatf("cnt%0d", c), 32'(sent_count[c*CW +: CW]), 32'(m_cnt[c]));
        end
    endtask

    task automatic step();
        for (int c = 0; c < NC; c++) begin
            if (valid[c] && ready[c]) begin
                $display("xfer ch%0d data=%02h count=%0d t=%0t", c, data[c*DW +: DW],
                         sent_count[c*CW +: CW], $time);
                if (c == 0) xq.push_back(data[DW-1:0]);
            end
        end
        model_tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(valid), 32'd0);
        chk("async_cnt", 32'(sent_count), 32'd0);
        chk("async_data", 32'(data), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        int n_nz;
        bit dup;
        rst = 1'b1; enable = '0; gap_mode = 2'd0; fixed_gap = '0; pattern = 1'b0; ready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Back-to-back incrementing on ch0 only
        enable = 2'b01; ready = 2'b11;
        repeat (11) step();
        chk("cnt_after_10", 32'(sent_count[CW-1:0]), 32'd10);
        step();

        // Fixed gap of 3: one transfer every 4 cycles
        gap_mode = 2'd1; fixed_gap = 5'd3;
        xq.delete();
        repeat (16) step();
        chk("gap3_xfers", 32'(xq.size()), 32'd4);

        // Backpressure then release
        gap_mode = 2'd0; ready = 2'b00;
        repeat (5) step();
        ready = 2'b11;
        repeat (2) step();

        // Drop enable while stalled; exactly one more transfer
        ready = 2'b00; enable = 2'b00;
        repeat (2) step();
        ready = 2'b11;
        xq.delete();
        repeat (5) step();
        chk("drop_enable_xfers", 32'(xq.size()), 32'd1);

        // Randomized traffic on both channels
        for (int i = 0; i < 400; i++) begin
            enable    = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
            ready     = 2'($urandom);
            gap_mode  = 2'($urandom);
            fixed_gap = 5'($urandom_range(0, 4));
            pattern   = 1'($urandom);
            step();
        end

        // Park both channels in VALID, then reset asynchronously mid-cycle
        enable = 2'b11; ready = 2'b00; gap_mode = 2'd0;
        repeat (35) step();
        chk("pre_reset_valid", 32'(valid), 32'd3);
        async_reset();
        enable = 2'b01; ready = 2'b11; pattern = 1'b0;
        repeat (5) step();

        // LFSR sequence length and counter wrap after a fresh reset
        async_reset();
        enable = 2'b01; ready = 2'b11; pattern = 1'b1; gap_mode = 2'd0;
        step();
        xq.delete();
        repeat (256) step();
        chk("cnt_wrap", 32'(sent_count[CW-1:0]), 32'd0);
        chk("lfsr_first", 32'(xq[0]), 32'd1);
        n_nz = 0; dup = 0;
        for (int i = 0; i < 255; i++) begin
            if (xq[i] != 0) n_nz++;
            for (int j = 0; j < i; j++) if (xq[j] == xq[i]) dup = 1;
        end
        chk("lfsr_nonzero", 32'(n_nz), 32'd255);
        chk("lfsr_dup", 32'(dup), 32'd0);
        chk("lfsr_repeat", 32'(xq[255]), 32'(xq[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
